// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 5-stage RV32I pipeline: owns the PC and the
// IF/ID register, applying stall, flush and EX-stage redirects.
module fetch_stage #(
  parameter int                     DATA_WIDTH  = 32,
  parameter int                     INSTR_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]  RESET_PC    = 32'h0000_0000,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stallF,
  input  logic                   flushD,
  input  logic                   pcSrcE,
  input  logic [DATA_WIDTH-1:0]  pcTargetE,
  input  logic [INSTR_WIDTH-1:0] instrF,
  output logic [DATA_WIDTH-1:0]  pcF,
  output logic [INSTR_WIDTH-1:0] instrD,
  output logic [DATA_WIDTH-1:0]  pcD,
  output logic [DATA_WIDTH-1:0]  pcPlus4D,
  output logic                   validD,
  output logic [31:0]            fetchCount
);

  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] pc_next;
  logic                  load_d;
  logic                  target_unused;

  // Compressed instructions are not supported, so the target's low bits are dropped.
  assign target_unused = ^pcTargetE[1:0];

  assign pc_plus4 = pcF + DATA_WIDTH'(4);
  assign load_d   = !flushD && !stallF;

  always_comb begin
    // NOTE: default first so every path assigns pc_next and no latch is inferred.
    pc_next = pc_plus4;
    if (pcSrcE)
      pc_next = {pcTargetE[DATA_WIDTH-1:2], 2'b00};
    else if (stallF)
      pc_next = pcF;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)
      pcF <= RESET_PC;
    else
      pcF <= pc_next;
  end

  always_ff @(posedge clk) begin
    if (rst || flushD) begin
      instrD   <= NOP_INSTR;
      pcD      <= '0;
      pcPlus4D <= '0;
      validD   <= 1'b0;
    end else if (load_d) begin
      instrD   <= instrF;
      pcD      <= pcF;
      pcPlus4D <= pc_plus4;
      validD   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      fetchCount <= '0;
    else if (load_d)
      fetchCount <= fetchCount + 32'd1;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a scoreboard queue of expected IF/ID
// loads plus scenario tasks with directed checks.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stallF, flushD, pcSrcE;
  logic [31:0] pcTargetE, instrF, pcF, instrD, pcD, pcPlus4D, fetchCount;
  logic        validD;
  logic [31:0] mem_key = 32'h0;

  always #5 clk = ~clk;

  // Combinational instruction memory: word = address XOR a bench-chosen key.
  assign instrF = pcF ^ mem_key;

  fetch_stage #(
    .DATA_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk(clk), .rst(rst), .stallF(stallF), .flushD(flushD), .pcSrcE(pcSrcE),
    .pcTargetE(pcTargetE), .instrF(instrF), .pcF(pcF), .instrD(instrD),
    .pcD(pcD), .pcPlus4D(pcPlus4D), .validD(validD), .fetchCount(fetchCount)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] p4;
  } exp_t;

  exp_t        sbq[$];
  exp_t        cur;
  logic [31:0] m_pc    = RESET_PC;
  logic [31:0] m_count = 32'h0;
  logic        m_valid = 1'b0;
  int          n_checks = 0;
  int          n_fail   = 0;

  // Drives one cycle, advances the reference model, and scoreboards the result.
  task automatic tick(input logic r, input logic s, input logic f,
                      input logic src, input logic [31:0] tgt);
    exp_t e;
    logic load;
    rst = r; stallF = s; flushD = f; pcSrcE = src; pcTargetE = tgt;
    #1;
    load = !r && !f && !s;
    if (r) begin
      m_pc = RESET_PC; m_count = 32'h0; m_valid = 1'b0; sbq.delete();
    end else begin
      if (load) begin
        e.instr = m_pc ^ mem_key; e.pc = m_pc; e.p4 = m_pc + 32'd4;
        sbq.push_back(e);
        m_count = m_count + 32'd1;
        m_valid = 1'b1;
      end else if (f) begin
        m_valid = 1'b0;
      end
      if (src)     m_pc = {tgt[31:2], 2'b00};
      else if (!s) m_pc = m_pc + 32'd4;
    end
    @(posedge clk); #1;
    if (load) begin
      n_checks++;
      if (sbq.size() == 0) begin
        n_fail++; $display("FAIL sb_empty: got no expected entry, required one");
      end else cur = sbq.pop_front();
    end
    n_checks++;
    if (pcF !== m_pc) begin
      n_fail++; $display("FAIL sb_pcF: got %h required %h", pcF, m_pc);
    end
    n_checks++;
    if (fetchCount !== m_count) begin
      n_fail++; $display("FAIL sb_count: got %0d required %0d", fetchCount, m_count);
    end
    n_checks++;
    if (validD !== m_valid) begin
      n_fail++; $display("FAIL sb_valid: got %b required %b", validD, m_valid);
    end
    n_checks++;
    if (m_valid) begin
      if (instrD !== cur.instr || pcD !== cur.pc || pcPlus4D !== cur.p4) begin
        n_fail++;
        $display("FAIL sb_ifid: got %h/%h/%h required %h/%h/%h",
                 instrD, pcD, pcPlus4D, cur.instr, cur.pc, cur.p4);
      end
    end else if (instrD !== NOP_INSTR || pcD !== 32'h0 || pcPlus4D !== 32'h0) begin
      n_fail++;
      $display("FAIL sb_bubble: got %h/%h/%h required %h/0/0",
               instrD, pcD, pcPlus4D, NOP_INSTR);
    end
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0, 32'h0);
    tick(1, 1, 1, 1, 32'h80);
    n_checks++;
    if (pcF !== RESET_PC || instrD !== NOP_INSTR || validD !== 1'b0 || fetchCount !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: got pc=%h instr=%h v=%b cnt=%0d required %h %h 0 0",
               pcF, instrD, validD, fetchCount, RESET_PC, NOP_INSTR);
    end
  endtask

  task automatic test_free_run();
    tick(0, 0, 0, 0, 32'h0);
    n_checks++;
    if (pcF !== 32'h4 || instrD !== 32'h0 || pcD !== 32'h0 || pcPlus4D !== 32'h4 || validD !== 1'b1) begin
      n_fail++;
      $display("FAIL run_first: got pc=%h instr=%h pcD=%h p4=%h v=%b required 4 0 0 4 1",
               pcF, instrD, pcD, pcPlus4D, validD);
    end
    tick(0, 0, 0, 0, 32'h0);
    n_checks++;
    if (pcF !== 32'h8 || instrD !== 32'h4 || pcD !== 32'h4 || fetchCount !== 32'd2) begin
      n_fail++;
      $display("FAIL run_second: got pc=%h instr=%h pcD=%h cnt=%0d required 8 4 4 2",
               pcF, instrD, pcD, fetchCount);
    end
  endtask

  task automatic test_stall();
    tick(0, 1, 0, 0, 32'h0);
    tick(0, 1, 0, 0, 32'h0);
    n_checks++;
    if (pcF !== 32'h8 || instrD !== 32'h4 || pcD !== 32'h4 || fetchCount !== 32'd2 || validD !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_hold: got pc=%h instr=%h pcD=%h cnt=%0d v=%b required 8 4 4 2 1",
               pcF, instrD, pcD, fetchCount, validD);
    end
    tick(0, 0, 0, 0, 32'h0);
    n_checks++;
    if (pcF !== 32'hC || instrD !== 32'h8 || fetchCount !== 32'd3) begin
      n_fail++;
      $display("FAIL stall_release: got pc=%h instr=%h cnt=%0d required c 8 3",
               pcF, instrD, fetchCount);
    end
  endtask

  task automatic test_redirect();
    tick(0, 0, 0, 0, 32'h0);
    tick(0, 0, 1, 1, 32'h0000_0103);
    n_checks++;
    if (pcF !== 32'h100 || instrD !== NOP_INSTR || validD !== 1'b0 || pcD !== 32'h0 || fetchCount !== 32'd4) begin
      n_fail++;
      $display("FAIL redirect: got pc=%h instr=%h v=%b pcD=%h cnt=%0d required 100 13 0 0 4",
               pcF, instrD, validD, pcD, fetchCount);
    end
    tick(0, 0, 0, 0, 32'h0);
    n_checks++;
    if (instrD !== 32'h100 || validD !== 1'b1 || pcF !== 32'h104) begin
      n_fail++;
      $display("FAIL redirect_target: got instr=%h v=%b pc=%h required 100 1 104",
               instrD, validD, pcF);
    end
  endtask

  task automatic test_conflict();
    tick(0, 1, 1, 0, 32'h0);
    n_checks++;
    if (pcF !== 32'h104 || validD !== 1'b0 || instrD !== NOP_INSTR) begin
      n_fail++;
      $display("FAIL stall_flush: got pc=%h v=%b instr=%h required 104 0 13",
               pcF, validD, instrD);
    end
    tick(0, 1, 0, 1, 32'h40);
    n_checks++;
    if (pcF !== 32'h40 || validD !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_redirect: got pc=%h v=%b required 40 0", pcF, validD);
    end
  endtask

  task automatic test_wrap();
    tick(0, 0, 1, 1, 32'hFFFF_FFFC);
    tick(0, 0, 0, 0, 32'h0);
    n_checks++;
    if (pcF !== 32'h0 || pcD !== 32'hFFFF_FFFC || pcPlus4D !== 32'h0 || instrD !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap: got pc=%h pcD=%h p4=%h instr=%h required 0 fffffffc 0 fffffffc",
               pcF, pcD, pcPlus4D, instrD);
    end
  endtask

  task automatic test_reset_mid();
    tick(0, 0, 1, 1, 32'h40);
    tick(1, 1, 0, 0, 32'h0);
    n_checks++;
    if (pcF !== RESET_PC || instrD !== NOP_INSTR || validD !== 1'b0 || fetchCount !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got pc=%h instr=%h v=%b cnt=%0d required %h 13 0 0",
               pcF, instrD, validD, fetchCount, RESET_PC);
    end
    tick(0, 0, 0, 0, 32'h0);
    n_checks++;
    if (instrD !== RESET_PC || pcD !== RESET_PC || validD !== 1'b1 || fetchCount !== 32'd1) begin
      n_fail++;
      $display("FAIL reset_first_load: got instr=%h pcD=%h v=%b cnt=%0d required %h %h 1 1",
               instrD, pcD, validD, fetchCount, RESET_PC, RESET_PC);
    end
  endtask

  // Distinct data pattern so instrD cannot alias pcD; includes an unflushed redirect.
  task automatic test_back_to_back();
    mem_key = 32'hA5A5_0F00;
    tick(0, 0, 0, 1, 32'h0000_0201);
    n_checks++;
    if (validD !== 1'b1 || instrD !== (pcD ^ 32'hA5A5_0F00) || pcF !== 32'h200) begin
      n_fail++;
      $display("FAIL redirect_noflush: got v=%b instr=%h pcD=%h pc=%h required 1 pcD^key 200",
               validD, instrD, pcD, pcF);
    end
    for (int i = 0; i < 40; i++) begin
      tick(0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 7) == 0), $urandom());
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_conflict();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register of the 5-stage RV32I pipeline. It owns the program counter and drives the instruction-memory address. It captures the returned instruction into the decode-side register that feeds the decoder and the immediate extender. It also applies stall, flush and branch/jump redirect requests from the hazard unit and the execute stage.

Parameters:
DATA_WIDTH, 32, width of PC and address datapath
INSTR_WIDTH, 32, instruction word width
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
stallF  input  1  hold PC and IF/ID contents this cycle
flushD  input  1  replace IF/ID contents with bubble
pcSrcE  input  1  redirect fetch to pcTargetE (taken branch / jump in EX)
pcTargetE  input  DATA_WIDTH  redirect target from EX
instrF  input  INSTR_WIDTH  instruction-memory read data for address pcF (combinational memory)
pcF  output  DATA_WIDTH  current fetch address to instruction memory
instrD  output  INSTR_WIDTH  instruction presented to decode
pcD  output  DATA_WIDTH  address of instrD
pcPlus4D  output  DATA_WIDTH  pcD + 4
validD  output  1  1 = instrD is a real fetched instruction, 0 = bubble
fetchCount  output  32  number of instructions loaded into IF/ID since reset

Behaviour:
- One clock domain. Reset is synchronous and active-high; rst overrides every other input.
- Reset values: pcF=RESET_PC, instrD=NOP_INSTR, pcD=0, pcPlus4D=0, validD=0, fetchCount=0.
- PC next-state, in priority order:
  - pcSrcE=1: pcF <= {pcTargetE[DATA_WIDTH-1:2], 2'b00}. Low two bits are forced to zero because compressed instructions are not supported.
  - stallF=1: pcF holds.
  - Otherwise: pcF <= pcF + 4, modulo 2^DATA_WIDTH. 32'hFFFF_FFFC wraps to 0.
- IF/ID next-state, in priority order:
  - flushD=1: instrD <= NOP_INSTR, pcD <= 0, pcPlus4D <= 0, validD <= 0.
  - stallF=1: all IF/ID fields hold, including validD.
  - Otherwise: instrD <= instrF, pcD <= pcF, pcPlus4D <= pcF + 4 (wrapping), validD <= 1.
- Latency: an instruction at address A appears on instrD exactly 1 cycle after pcF=A, provided there is no stall or flush in that cycle.
- Redirect pairing: the hazard unit asserts flushD together with pcSrcE. The wrong-path instruction fetched in the redirect cycle is discarded via flushD. If pcSrcE=1 and flushD=0, the fetched instruction is still captured; this is not an error condition.
- Simultaneous events:
  - flushD with stallF: flush wins for IF/ID.
  - pcSrcE with stallF: redirect wins for PC.
  - rst with anything: reset wins.
- fetchCount increments by 1 on every clock edge where IF/ID loads with validD <= 1, i.e. not rst, not flushD, not stallF. It wraps at 2^32. It does not change on stall, flush or bubble cycles.
- Reset mid-operation: all state returns to reset values on the next edge. The first post-reset edge loads the instruction at RESET_PC into IF/ID.
- pcF, and all IF/ID outputs, are register outputs with no combinational path from the inputs.

Test Plan:
- Reset then free-run, memory returning word = address: after rst low, pcF sequence 0,4,8,12. instrD/pcD lag pcF by one cycle (instrD=0,pcD=0,pcPlus4D=4 then instrD=4,pcD=4). validD=1 from the first post-reset edge. fetchCount = 3 after 3 loads.
- Stall: assert stallF for 2 cycles while pcF=8. pcF stays 8, instrD/pcD stay at the address-4 values and fetchCount freezes. On release, pcF advances to 12 and instrD=8.
- Redirect: at pcF=16, pulse pcSrcE=1, flushD=1, pcTargetE=32'h0000_0103. Next cycle pcF=32'h100, instrD=0x13, validD=0, pcD=0, fetchCount unchanged. The following cycle instrD=0x100, validD=1.
- Conflict priority: stallF=1 and flushD=1 together give a bubble in IF/ID while pcF holds. stallF=1 and pcSrcE=1, pcTargetE=0x40, give pcF=0x40.
- Wrap-around: drive redirect to 32'hFFFF_FFFC. Next pcF=0. The captured pcD=FFFF_FFFC has pcPlus4D=0.
- Reset mid-stream: assert rst for one cycle at pcF=0x40 with stallF=1. Next cycle pcF=RESET_PC, instrD=0x13, validD=0, fetchCount=0.
